// File: rtl/cv32e40p_pkg.sv
// Shared ALU-selection types: operator encodings, op-class constants, class decoder and FSM states.
package cv32e40p_pkg;

    localparam int unsigned ALU_OP_WIDTH = 7;
    localparam int unsigned N_ALU        = 4;
    localparam int unsigned N_CLASS      = 9;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = 7'b0011000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB   = 7'b0011001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA   = 7'b0100100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL   = 7'b0100101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL   = 7'b0100111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR   = 7'b0101111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR    = 7'b0101110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND   = 7'b0010101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BEXT  = 7'b0101000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BCLR  = 7'b0101011;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BSET  = 7'b0101100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_FF1   = 7'b0110110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_CNT   = 7'b0110100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SHUF  = 7'b0111010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_PCKLO = 7'b0111000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS   = 7'b0000000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ    = 7'b0001100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS  = 7'b0000010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ABS   = 7'b0010100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_CLIP  = 7'b0010110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MIN   = 7'b0010000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MAX   = 7'b0010010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV   = 7'b0110001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REM   = 7'b0110011;

    localparam logic [3:0] ALU_CLASS_ADD     = 4'd0;
    localparam logic [3:0] ALU_CLASS_LOGIC   = 4'd1;
    localparam logic [3:0] ALU_CLASS_BITMAN  = 4'd2;
    localparam logic [3:0] ALU_CLASS_BITCNT  = 4'd3;
    localparam logic [3:0] ALU_CLASS_SHUFFLE = 4'd4;
    localparam logic [3:0] ALU_CLASS_CMP     = 4'd5;
    localparam logic [3:0] ALU_CLASS_ABSCLIP = 4'd6;
    localparam logic [3:0] ALU_CLASS_MINMAX  = 4'd7;
    localparam logic [3:0] ALU_CLASS_DIV     = 4'd8;
    localparam logic [3:0] ALU_CLASS_NONE    = 4'd9;

    typedef enum logic {
        ALU_SEL_RUN,
        ALU_SEL_RECONF
    } alu_sel_state_e;

    function automatic logic [3:0] alu_op_class(input logic [ALU_OP_WIDTH-1:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_SRA, ALU_SRL, ALU_SLL: return ALU_CLASS_ADD;
            ALU_XOR, ALU_OR, ALU_AND:                    return ALU_CLASS_LOGIC;
            ALU_BEXT, ALU_BCLR, ALU_BSET:                return ALU_CLASS_BITMAN;
            ALU_FF1, ALU_CNT:                            return ALU_CLASS_BITCNT;
            ALU_SHUF, ALU_PCKLO:                         return ALU_CLASS_SHUFFLE;
            ALU_LTS, ALU_EQ, ALU_SLTS:                   return ALU_CLASS_CMP;
            ALU_ABS, ALU_CLIP:                           return ALU_CLASS_ABSCLIP;
            ALU_MIN, ALU_MAX:                            return ALU_CLASS_MINMAX;
            ALU_DIV, ALU_REM:                            return ALU_CLASS_DIV;
            default:                                     return ALU_CLASS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cv32e40p_alu_sel_pick_ft.sv
// Picks the lowest three healthy ALUs and the matching voter input selects.
module cv32e40p_alu_sel_pick_ft
    import cv32e40p_pkg::*;
(
    input  logic [3:0]      healthy_i,
    output logic [3:0]      mask_o,
    output logic [2:0][1:0] vote_sel_o,
    output logic [2:0]      n_healthy_o
);

    logic [1:0] n_sel;

    always_comb begin
        mask_o      = '0;
        vote_sel_o  = '0;
        n_healthy_o = '0;
        n_sel       = '0;
        for (int i = 0; i < N_ALU; i++) begin
            if (healthy_i[i]) begin
                n_healthy_o = n_healthy_o + 3'd1;
                if (n_sel != 2'd3) begin
                    mask_o[i]         = 1'b1;
                    vote_sel_o[n_sel] = 2'(i);
                    n_sel             = n_sel + 2'd1;
                end
            end
        end
        // Pad the unused voter inputs so a DMR pair still disagrees visibly.
        case (n_sel)
            2'd2: vote_sel_o[2] = vote_sel_o[0];
            2'd1: begin
                vote_sel_o[1] = vote_sel_o[0];
                vote_sel_o[2] = vote_sel_o[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cv32e40p_alu_sel_ft.sv
// Fault-tolerant ALU selection at ID/EX; rebuilds the per-class table on fault-map changes.
// Optional spare rotation among fully healthy classes: CV32E40P_ALU_SEL_SPARE_ROTATE_EN.
module cv32e40p_alu_sel_ft
    import cv32e40p_pkg::*;
#(
    parameter int unsigned ROTATE_PERIOD = 256
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                id_valid_i,
    input  logic                                ex_ready_i,
    input  logic [ALU_OP_WIDTH-1:0]             alu_operator_i,
    input  logic [N_ALU-1:0][N_CLASS-1:0]       permanent_faulty_alu_i,
    output logic [3:0]                          alu_enable_o,
    output logic [2:0][1:0]                     vote_sel_o,
    output logic [3:0]                          clock_en_o,
    output logic                                reconf_stall_o,
    output logic                                degraded_o,
    output logic                                fatal_o
);

    if (ROTATE_PERIOD < 1) begin : g_bad_period
        $error("ROTATE_PERIOD must be at least 1");
    end

    alu_sel_state_e                state_q, state_d;
    logic [3:0]                    idx_q, idx_d;
    logic [N_ALU-1:0][N_CLASS-1:0] snap_q, snap_d;
    logic [N_CLASS-1:0][3:0]       mask_q, mask_d;
    logic [N_CLASS-1:0]            degr_q, degr_d;
    logic [N_CLASS-1:0]            fatal_q, fatal_d;
    logic [3:0]                    en_q, en_d;
    logic [3:0]                    clk_en_q, clk_en_d;
    logic [2:0][1:0]               vote_q, vote_d;
    logic                          stall_q, stall_d;

    logic                          map_changed, accept, cls_valid;
    logic [3:0]                    op_cls, cls_sel;
    logic [3:0]                    scan_healthy, scan_mask, eff_mask, iss_mask;
    logic [2:0]                    scan_n, iss_n;
    logic [2:0][1:0]               iss_vote;

    assign map_changed = (permanent_faulty_alu_i != snap_q);
    assign accept      = id_valid_i & ex_ready_i & (state_q == ALU_SEL_RUN) & ~map_changed;
    assign op_cls      = alu_op_class(alu_operator_i);
    assign cls_valid   = (op_cls != ALU_CLASS_NONE);
    assign cls_sel     = cls_valid ? op_cls : 4'd0;

    always_comb begin
        for (int a = 0; a < N_ALU; a++) begin
            scan_healthy[a] = ~snap_q[a][idx_q];
        end
    end

    cv32e40p_alu_sel_pick_ft u_scan_pick (
        .healthy_i   (scan_healthy),
        .mask_o      (scan_mask),
        .vote_sel_o  (),
        .n_healthy_o (scan_n)
    );

`ifdef CV32E40P_ALU_SEL_SPARE_ROTATE_EN
    localparam int unsigned CNT_W = (ROTATE_PERIOD > 1) ? $clog2(ROTATE_PERIOD) : 1;

    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic [1:0]       rot_ptr_q, rot_ptr_d;
    logic [3:0]       cls_flags;

    always_comb begin
        for (int a = 0; a < N_ALU; a++) begin
            cls_flags[a] = snap_q[a][cls_sel];
        end
        eff_mask = (cls_flags == 4'b0000) ? ~(4'b0001 << rot_ptr_q) : mask_q[cls_sel];
        op_cnt_d  = op_cnt_q;
        rot_ptr_d = rot_ptr_q;
        if (accept) begin
            if (op_cnt_q == CNT_W'(ROTATE_PERIOD - 1)) begin
                op_cnt_d  = '0;
                rot_ptr_d = rot_ptr_q + 2'd1;
            end else begin
                op_cnt_d = op_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q  <= '0;
            rot_ptr_q <= 2'd3;
        end else begin
            op_cnt_q  <= op_cnt_d;
            rot_ptr_q <= rot_ptr_d;
        end
    end
`else
    assign eff_mask = mask_q[cls_sel];
`endif

    cv32e40p_alu_sel_pick_ft u_issue_pick (
        .healthy_i   (eff_mask),
        .mask_o      (iss_mask),
        .vote_sel_o  (iss_vote),
        .n_healthy_o (iss_n)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        mask_d  = mask_q;
        degr_d  = degr_q;
        fatal_d = fatal_q;
        case (state_q)
            ALU_SEL_RUN: begin
                if (map_changed) begin
                    snap_d  = permanent_faulty_alu_i;
                    idx_d   = '0;
                    state_d = ALU_SEL_RECONF;
                end
            end
            ALU_SEL_RECONF: begin
                // A new map mid-scan invalidates everything scanned so far.
                if (map_changed) begin
                    snap_d = permanent_faulty_alu_i;
                    idx_d  = '0;
                end else begin
                    mask_d[idx_q]  = scan_mask;
                    degr_d[idx_q]  = (scan_n == 3'd2);
                    fatal_d[idx_q] = (scan_n < 3'd2);
                    if (idx_q == 4'(N_CLASS - 1)) begin
                        idx_d   = '0;
                        state_d = ALU_SEL_RUN;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = ALU_SEL_RUN;
        endcase
        stall_d = (state_d == ALU_SEL_RECONF);
    end

    always_comb begin
        en_d     = en_q;
        clk_en_d = clk_en_q;
        vote_d   = vote_q;
        if (ex_ready_i) begin
            if (accept && !cls_valid) begin
                en_d     = 4'b0001;
                clk_en_d = 4'b0000;
                vote_d   = '0;
            end else if (accept) begin
                en_d     = (iss_n == 3'd0) ? 4'b0000 : iss_mask;
                clk_en_d = (iss_n == 3'd0) ? 4'b0000 : iss_mask;
                vote_d   = iss_vote;
            end else begin
                en_d     = 4'b0000;
                clk_en_d = 4'b0000;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ALU_SEL_RUN;
            idx_q    <= '0;
            snap_q   <= '0;
            mask_q   <= {N_CLASS{4'b0111}};
            degr_q   <= '0;
            fatal_q  <= '0;
            en_q     <= '0;
            clk_en_q <= '0;
            vote_q   <= {2'd2, 2'd1, 2'd0};
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            snap_q   <= snap_d;
            mask_q   <= mask_d;
            degr_q   <= degr_d;
            fatal_q  <= fatal_d;
            en_q     <= en_d;
            clk_en_q <= clk_en_d;
            vote_q   <= vote_d;
            stall_q  <= stall_d;
        end
    end

    assign alu_enable_o   = en_q;
    assign clock_en_o     = clk_en_q;
    assign vote_sel_o     = vote_q;
    assign reconf_stall_o = stall_q;
    assign degraded_o     = |degr_q;
    assign fatal_o        = |fatal_q;

endmodule
